// File: rtl/rf_dump_tx.sv
// rf_dump_tx: streams a register-file dump as a byte frame.
// Frame: header 0xA5, then registers 0..7, each as 4 bytes MSB first.
// Optional feature macro: RF_DUMP_CHECKSUM_EN appends one XOR checksum byte
// over all register data bytes (header excluded).
// The register file is read through a combinational port: ra -> rd in the same cycle.
module rf_dump_tx (
  input  logic        clk,
  input  logic        n_rst,
  input  logic        start,
  output logic [2:0]  ra,
  input  logic [31:0] rd,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        busy,
  output logic        done
);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_HDR  = 3'd1,
    ST_LOAD = 3'd2,
`ifdef RF_DUMP_CHECKSUM_EN
    ST_SEND = 3'd3,
    ST_CSUM = 3'd4
`else
    ST_SEND = 3'd3
`endif
  } state_t;

  localparam logic [7:0] HDR_BYTE = 8'hA5;

  state_t      r_state;
  logic [2:0]  r_idx;
  logic [31:0] r_shift;
  logic [1:0]  r_cnt;
  logic [7:0]  r_tx_data;
  logic        r_tx_valid;
  logic        r_busy;
  logic        r_done;
  logic        w_xfer;
`ifdef RF_DUMP_CHECKSUM_EN
  logic [7:0]  r_csum;
`endif

  assign w_xfer   = r_tx_valid & tx_ready;
  assign ra       = r_idx;
  assign tx_data  = r_tx_data;
  assign tx_valid = r_tx_valid;
  assign busy     = r_busy;
  assign done     = r_done;

  // Frame sequencer: state, register index, byte shifter and all registered outputs.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_state    <= ST_IDLE;
      r_idx      <= 3'd0;
      r_shift    <= 32'd0;
      r_cnt      <= 2'd0;
      r_tx_data  <= 8'h00;
      r_tx_valid <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
`ifdef RF_DUMP_CHECKSUM_EN
      r_csum     <= 8'h00;
`endif
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          // start is only looked at here, so it is ignored (not queued) while busy
          if (start) begin
            r_state    <= ST_HDR;
            r_idx      <= 3'd0;
            r_tx_data  <= HDR_BYTE;
            r_tx_valid <= 1'b1;
            r_busy     <= 1'b1;
`ifdef RF_DUMP_CHECKSUM_EN
            r_csum     <= 8'h00;
`endif
          end
        end
        ST_HDR: begin
          if (w_xfer) begin
            r_state    <= ST_LOAD;
            r_idx      <= 3'd0;
            r_tx_valid <= 1'b0;
          end
        end
        ST_LOAD: begin
          // one-shot sample: later register-file writes cannot alter these 4 bytes
          r_shift    <= rd;
          r_tx_data  <= rd[31:24];
          r_tx_valid <= 1'b1;
          r_cnt      <= 2'd0;
          r_state    <= ST_SEND;
        end
        ST_SEND: begin
          if (w_xfer) begin
            r_shift   <= {r_shift[23:0], 8'h00};
            r_tx_data <= r_shift[23:16];
            r_cnt     <= r_cnt + 2'd1;
`ifdef RF_DUMP_CHECKSUM_EN
            r_csum    <= r_csum ^ r_shift[31:24];
`endif
            if (r_cnt == 2'd3) begin
              if (r_idx != 3'd7) begin
                r_idx      <= r_idx + 3'd1;
                r_tx_valid <= 1'b0;
                r_state    <= ST_LOAD;
              end else begin
`ifdef RF_DUMP_CHECKSUM_EN
                // the last data byte is folded in directly since r_csum updates this same edge
                r_tx_data  <= r_csum ^ r_shift[31:24];
                r_tx_valid <= 1'b1;
                r_state    <= ST_CSUM;
`else
                r_tx_valid <= 1'b0;
                r_busy     <= 1'b0;
                r_done     <= 1'b1;
                r_state    <= ST_IDLE;
`endif
              end
            end
          end
        end
`ifdef RF_DUMP_CHECKSUM_EN
        ST_CSUM: begin
          if (w_xfer) begin
            r_tx_valid <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b1;
            r_state    <= ST_IDLE;
          end
        end
`endif
        default: begin
          r_state    <= ST_IDLE;
          r_idx      <= 3'd0;
          r_tx_valid <= 1'b0;
          r_busy     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rf_dump_tx.sv
// Bench for rf_dump_tx: a queue-based frame model is built from a register
// snapshot at start acceptance; every cycle the DUT outputs are compared against it.
module tb_rf_dump_tx;

`ifdef RF_DUMP_CHECKSUM_EN
  localparam int FRAME_LEN = 34;
  localparam int DONE_LAT  = 42;
`else
  localparam int FRAME_LEN = 33;
  localparam int DONE_LAT  = 41;
`endif

  logic        clk;
  logic        n_rst;
  logic        start;
  logic [2:0]  ra;
  logic [31:0] rd;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        busy;
  logic        done;

  logic [31:0] regs [0:7];
  assign rd = regs[ra];

  rf_dump_tx dut (
    .clk(clk), .n_rst(n_rst), .start(start), .ra(ra), .rd(rd),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // model state
  logic [7:0] frame_q [$];
  logic [7:0] m_q [$];
  logic [7:0] rx_q [$];
  bit         m_busy = 1'b0;
  bit         m_done = 1'b0;
  int         m_xfer = 0;
  int         done_cnt = 0;
  bit         prev_stall = 1'b0;
  logic [7:0] prev_data = 8'h00;

  // stimulus controls
  int rdy_mode = 0;
  int mut_mode = 0;
  int stall_left = 0;
  int stalled_for = -1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // expected frame from the current register contents
  function automatic void build_frame();
    logic [7:0] c;
    logic [7:0] by;
    c = 8'h00;
    frame_q.delete();
    frame_q.push_back(8'hA5);
    for (int i = 0; i < 8; i++) begin
      for (int b = 3; b >= 0; b--) begin
        by = regs[i][8*b +: 8];
        frame_q.push_back(by);
        c = c ^ by;
      end
    end
`ifdef RF_DUMP_CHECKSUM_EN
    frame_q.push_back(c);
`else
    c = 8'h00;
`endif
  endfunction

  // per-cycle compare against the model, sampled mid-cycle
  always @(negedge clk) begin
    bit cur_busy;
    if (!n_rst) begin
      m_q.delete();
      m_busy = 1'b0;
      m_done = 1'b0;
      prev_stall = 1'b0;
    end else begin
      chk("busy", {31'd0, busy}, {31'd0, m_busy});
      chk("done", {31'd0, done}, {31'd0, m_done});
      if (!m_busy) chk("valid_when_idle", {31'd0, tx_valid}, 32'd0);
      if (tx_valid && m_q.size() > 0) chk("tx_data", {24'd0, tx_data}, {24'd0, m_q[0]});
      if (prev_stall) begin
        chk("stall_valid_hold", {31'd0, tx_valid}, 32'd1);
        chk("stall_data_hold", {24'd0, tx_data}, {24'd0, prev_data});
      end
      prev_stall = tx_valid && !tx_ready;
      prev_data  = tx_data;
      if (done) done_cnt++;
      cur_busy = m_busy;
      m_done = 1'b0;
      if (tx_valid && tx_ready && m_busy && m_q.size() > 0) begin
        rx_q.push_back(tx_data);
        void'(m_q.pop_front());
        m_xfer++;
        if (m_q.size() == 0) begin
          m_busy = 1'b0;
          m_done = 1'b1;
        end
      end
      if (start && !cur_busy) begin
        build_frame();
        m_q = frame_q;
        m_busy = 1'b1;
        m_xfer = 0;
        rx_q.delete();
      end
    end
  end

  // one clock step: drives ready per mode and mutates already-sampled registers
  task automatic cycle();
    int kmax;
    @(posedge clk);
    #2;
    start = 1'b0;
    case (rdy_mode)
      0: tx_ready = 1'b1;
      1: tx_ready = ($urandom_range(99, 0) < 70);
      default: begin
        if (m_busy && (m_xfer % 2 == 1) && stalled_for != m_xfer) begin
          stall_left = 3;
          stalled_for = m_xfer;
        end
        tx_ready = (stall_left == 0);
        if (stall_left > 0) stall_left--;
      end
    endcase
    if (mut_mode == 1 && m_busy && m_xfer >= 2) begin
      kmax = (m_xfer - 2) / 4;
      if (kmax > 7) kmax = 7;
      regs[$urandom_range(kmax, 0)] = $urandom;
    end else if (mut_mode == 2 && m_busy && m_xfer >= 10 && m_xfer <= 12) begin
      regs[2] = $urandom;
    end
  endtask

  task automatic wait_frame(input int d0, input bit repulse);
    bit pulsed;
    pulsed = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      if (done_cnt > d0) break;
      cycle();
      if (repulse && !pulsed && m_xfer >= 10) begin
        start = 1'b1;
        pulsed = 1'b1;
      end
    end
    chk("frame_completed", {31'd0, (done_cnt > d0)}, 32'd1);
    chk("frame_length", rx_q.size(), FRAME_LEN);
  endtask

  task automatic run_frame(input bit repulse);
    int d0;
    d0 = done_cnt;
    start = 1'b1;
    cycle();
    wait_frame(d0, repulse);
  endtask

  initial begin
    #2000000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int cnt;
    int d0;
    n_rst = 1'b0;
    start = 1'b0;
    tx_ready = 1'b1;
    for (int i = 0; i < 8; i++) regs[i] = 32'd1;
    #1;
    chk("rst_tx_valid", {31'd0, tx_valid}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_ra", {29'd0, ra}, 32'd0);
    chk("rst_tx_data", {24'd0, tx_data}, 32'd0);
    repeat (3) @(posedge clk);
    #2 n_rst = 1'b1;
    repeat (3) cycle();

    // model pins with hand-computed values
    build_frame();
    chk("pin_len", frame_q.size(), FRAME_LEN);
    chk("pin_hdr", {24'd0, frame_q[0]}, 32'h0000_00A5);
    chk("pin_r0b0", {24'd0, frame_q[1]}, 32'h0000_0000);
    chk("pin_r0b3", {24'd0, frame_q[4]}, 32'h0000_0001);
    chk("pin_r7b3", {24'd0, frame_q[32]}, 32'h0000_0001);
    for (int i = 0; i < 8; i++) regs[i] = 32'd0;
    regs[3] = 32'hDEADBEEF;
    build_frame();
    chk("pin_r3b0", {24'd0, frame_q[13]}, 32'h0000_00DE);
    chk("pin_r3b3", {24'd0, frame_q[16]}, 32'h0000_00EF);
`ifdef RF_DUMP_CHECKSUM_EN
    chk("pin_csum", {24'd0, frame_q[33]}, 32'h0000_0022);
`endif

    // all ones, ready held: exact done latency, then start in the done cycle
    for (int i = 0; i < 8; i++) regs[i] = 32'd1;
    start = 1'b1;
    @(posedge clk);
    #2 start = 1'b0;
    cnt = 0;
    for (int n = 0; n < 200; n++) begin
      @(posedge clk);
      cnt++;
      #1;
      if (done) break;
    end
    chk("done_latency", cnt, DONE_LAT);
    chk("ones_hdr", {24'd0, rx_q[0]}, 32'h0000_00A5);
    chk("ones_r7b3", {24'd0, rx_q[32]}, 32'h0000_0001);
    chk("ones_r4b2", {24'd0, rx_q[19]}, 32'h0000_0000);
    #1 start = 1'b1;
    for (int i = 0; i < 8; i++) regs[i] = 32'd0;
    regs[3] = 32'hDEADBEEF;
    @(posedge clk);
    #2 start = 1'b0;
    d0 = done_cnt;
    wait_frame(d0, 1'b0);
    chk("dead_b13", {24'd0, rx_q[13]}, 32'h0000_00DE);
    chk("dead_b14", {24'd0, rx_q[14]}, 32'h0000_00AD);
    chk("dead_b15", {24'd0, rx_q[15]}, 32'h0000_00BE);
    chk("dead_b16", {24'd0, rx_q[16]}, 32'h0000_00EF);
`ifdef RF_DUMP_CHECKSUM_EN
    chk("dead_csum", {24'd0, rx_q[33]}, 32'h0000_0022);
`endif

    // stall every second byte for 3 cycles
    for (int i = 0; i < 8; i++) regs[i] = $urandom;
    rdy_mode = 2;
    stalled_for = -1;
    run_frame(1'b0);

    // start re-pulsed mid-frame must be ignored
    rdy_mode = 0;
    d0 = done_cnt;
    run_frame(1'b1);
    repeat (60) cycle();
    chk("single_done", done_cnt - d0, 1);

    // register 2 rewritten while its bytes are in flight
    regs[2] = 32'h11223344;
    mut_mode = 2;
    run_frame(1'b0);
    mut_mode = 0;
    chk("r2_b0", {24'd0, rx_q[9]}, 32'h0000_0011);
    chk("r2_b3", {24'd0, rx_q[12]}, 32'h0000_0044);

    // reset during register 5
    start = 1'b1;
    cycle();
    for (int n = 0; n < 500; n++) begin
      if (m_xfer >= 22) break;
      cycle();
    end
    chk("reached_r5", {31'd0, (m_xfer >= 22)}, 32'd1);
    n_rst = 1'b0;
    #1;
    chk("mid_rst_valid", {31'd0, tx_valid}, 32'd0);
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    chk("mid_rst_ra", {29'd0, ra}, 32'd0);
    repeat (3) @(posedge clk);
    #2 n_rst = 1'b1;
    repeat (5) cycle();
    run_frame(1'b0);
    chk("post_rst_hdr", {24'd0, rx_q[0]}, 32'h0000_00A5);

    // randomized frames
    for (int f = 0; f < 20; f++) begin
      for (int i = 0; i < 8; i++) regs[i] = $urandom;
      rdy_mode = $urandom_range(2, 0);
      mut_mode = 1;
      stalled_for = -1;
      stall_left = 0;
      run_frame($urandom_range(1, 0) == 1);
      repeat ($urandom_range(3, 0)) cycle();
    end
    mut_mode = 0;
    rdy_mode = 0;
    repeat (5) cycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
